csa_operand_packer: RTL and testbench
=====================================

Name: csa_operand_packer

Overview:
- Upstream feeder for the 32-bit three-input carry-save adder stage.
- Accepts a valid/ready stream of W-bit operands, groups them into triples framed by in_last, and drives registered a/b/c operands with zero padding on short final groups.
- Produces a result-valid/last tag delayed by the adder's fixed 3-cycle latency, so downstream logic can qualify s/cout without its own counter.
- Enforces a drain gap after each frame so consecutive frames never interleave in the adder pipeline.

Parameters:
W, 32, operand width; must match the adder operand width.
CSA_LAT, 3, adder latency in cycles from operand registers to s/cout; valid range 1..7.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand word valid
in_ready  output  1  packer can accept a word this cycle
in_data  input  W  operand word
in_last  input  1  final word of the current frame
op_a  output  W  adder operand a (registered)
op_b  output  W  adder operand b (registered)
op_c  output  W  adder operand c (registered)
op_valid  output  1  op_a/op_b/op_c hold a real group this cycle
op_last  output  1  issued group is the last of its frame
res_valid  output  1  adder s/cout correspond to an issued group this cycle
res_last  output  1  qualifies res_valid as the frame's final result
grp_cnt  output  8  groups issued in the current frame; saturates at 255

Behaviour:
- Reset, asynchronous with rst_n low:
  - All outputs 0; internal slot registers 0; state IDLE0.
  - in_ready=0 while rst_n is low, and 1 in the first cycle after release.
  - Reset mid-frame discards held words and clears the latency shift register; no partial result is tagged.
- Accept condition: in_valid && in_ready on a rising clk edge.
- FSM fill states, held-word count:
  - IDLE0 (0 held): accept without last -> slotA<=data, go to HOLD1. Accept with last -> issue {data,0,0}, go to DRAIN.
  - HOLD1 (1 held): accept without last -> slotB<=data, go to HOLD2. Accept with last -> issue {slotA,data,0}, go to DRAIN.
  - HOLD2 (2 held): accept without last -> issue {slotA,slotB,data}, go to IDLE0. Accept with last -> issue the same triple, go to DRAIN.
- DRAIN state:
  - in_ready=0 for exactly CSA_LAT cycles, counted by a drain counter, then return to IDLE0.
  - in_ready=1 in all other states.
- Issue:
  - On the accepting edge, op_a/op_b/op_c are loaded with the group and op_valid=1 for exactly one cycle.
  - op_last=1 when the issue was caused by in_last.
  - In non-issue cycles op_a/op_b/op_c=0 and op_valid=op_last=0, so the adder computes 0.
  - Issue latency: the group appears on op_* the cycle after the completing word is accepted.
- grp_cnt:
  - Increments on each issue, saturating at 255.
  - Cleared to 0 on the cycle following an op_last issue.
- Result tagging:
  - Shift register of CSA_LAT stages carrying {op_valid, op_last}.
  - res_valid/res_last are asserted CSA_LAT cycles after op_valid/op_last, aligned with the adder's s/cout.
- Back-to-back: with continuous in_valid, one group is issued every 3 accepted words; no bubbles except DRAIN.
- in_last with in_valid=0 is ignored.
- in_data is don't-care when not accepted.
- No downstream stall: the adder pipeline cannot stall, so the packer never holds op_* awaiting a consumer.

Decomposition:
- Shared package csa_pkg:
  - Constant CSA_W=32 and CSA_LATENCY=3.
  - typedef enum fill_state_t {IDLE0, HOLD1, HOLD2, DRAIN}.
  - typedef struct csa_tag_t {valid, last}.
- One natural sub-module: csa_tag_delay, a parameterised CSA_LAT-deep shift register of csa_tag_t with async reset. It is reused by any future block that must align tags with the adder.

Test Plan:
- Reset release, then words 1,2,3 (last on 3) -> op_a=1, op_b=2, op_c=3, op_valid=op_last=1 one cycle after word 3; res_valid=res_last=1 exactly 3 cycles later; adder s=6.
- Single-word frame 0xFFFFFFFF with last -> op={0xFFFFFFFF,0,0}; in_ready low for 3 cycles, then high.
- Two-word frame 0xFFFFFFFF, 0x00000001 (last) -> op_c=0; res_last aligned with adder s=0x1_00000000.
- Continuous 9-word frame 1..9 -> three issues {1,2,3},{4,5,6},{7,8,9}; grp_cnt 1,2,3; op_last only on the third; then grp_cnt returns to 0.
- Assert rst_n low while in HOLD2 and with tags in flight -> all outputs 0 immediately; after release, no res_valid appears and the next frame starts from IDLE0.
- in_valid toggled with in_ready low during DRAIN -> no words accepted; words offered during DRAIN are taken after the gap, with slotA holding the first post-drain word.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and constants for the three-input carry-save adder feeder path.
package csa_pkg;

  localparam int CSA_W       = 32;
  localparam int CSA_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE0 = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2,
    DRAIN = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } csa_tag_t;

endpackage

// File: rtl/csa_operand_packer_if.sv
// Operand stream in, registered adder operands and result tags out.
interface csa_operand_packer_if #(
  parameter int W = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] op_c;
  logic         op_valid;
  logic         op_last;
  logic         res_valid;
  logic         res_last;
  logic [7:0]   grp_cnt;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, op_a, op_b, op_c, op_valid, op_last,
    input  res_valid, res_last, grp_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, op_a, op_b, op_c, op_valid, op_last,
    output res_valid, res_last, grp_cnt
  );

endinterface

// File: rtl/csa_tag_delay.sv
// Fixed-depth shift register that aligns valid/last tags with the adder's s/cout.
module csa_tag_delay
  import csa_pkg::*;
#(
  parameter int LAT = CSA_LATENCY
) (
  input  logic     clk,
  input  logic     rst_n,
  input  csa_tag_t tag_in,
  output csa_tag_t tag_out
);

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      csa_tag_t stage_reg;
      csa_tag_t stage_next;

      if (gi == 0) begin : g_head
        assign stage_next = tag_in;
      end else begin : g_tail
        assign stage_next = g_stage[gi-1].stage_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= stage_next;
        end
      end
    end
  endgenerate

  assign tag_out = g_stage[LAT-1].stage_reg;

endmodule

// File: rtl/csa_operand_packer.sv
// Packs a framed operand stream into zero-padded triples for the CSA stage and
// tags the adder output so downstream logic can qualify s/cout directly.
module csa_operand_packer
  import csa_pkg::*;
#(
  parameter int W       = CSA_W,
  parameter int CSA_LAT = CSA_LATENCY
) (
  input logic                 clk,
  input logic                 rst_n,
  csa_operand_packer_if.slave bus
);

  fill_state_t  state_reg;
  logic         in_ready_reg;
  logic [2:0]   drain_cnt_reg;
  logic [W-1:0] slot_a_reg;
  logic [W-1:0] slot_b_reg;
  logic [W-1:0] op_a_reg;
  logic [W-1:0] op_b_reg;
  logic [W-1:0] op_c_reg;
  logic         op_valid_reg;
  logic         op_last_reg;
  logic [7:0]   grp_cnt_reg;

  logic         accept;
  logic         issue;
  logic [W-1:0] grp_a;
  logic [W-1:0] grp_b;
  logic [W-1:0] grp_c;

  // Group assembled from held slots plus the word being accepted; short
  // groups are padded with zeros so the adder sees a neutral operand.
  always_comb begin
    accept = bus.in_valid && in_ready_reg;
    issue  = accept && ((state_reg == HOLD2) || bus.in_last);
    grp_a  = '0;
    grp_b  = '0;
    grp_c  = '0;
    case (state_reg)
      IDLE0: grp_a = bus.in_data;
      HOLD1: begin
        grp_a = slot_a_reg;
        grp_b = bus.in_data;
      end
      HOLD2: begin
        grp_a = slot_a_reg;
        grp_b = slot_b_reg;
        grp_c = bus.in_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE0;
      in_ready_reg  <= 1'b0;
      drain_cnt_reg <= '0;
      slot_a_reg    <= '0;
      slot_b_reg    <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      op_c_reg      <= '0;
      op_valid_reg  <= 1'b0;
      op_last_reg   <= 1'b0;
      grp_cnt_reg   <= '0;
    end else begin
      op_a_reg     <= issue ? grp_a : '0;
      op_b_reg     <= issue ? grp_b : '0;
      op_c_reg     <= issue ? grp_c : '0;
      op_valid_reg <= issue;
      op_last_reg  <= issue && bus.in_last;
      in_ready_reg <= 1'b1;

      if (op_valid_reg && op_last_reg) begin
        grp_cnt_reg <= '0;
      end else if (issue && (grp_cnt_reg != 8'hFF)) begin
        grp_cnt_reg <= grp_cnt_reg + 8'd1;
      end

      case (state_reg)
        IDLE0: begin
          if (accept) begin
            if (bus.in_last) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              drain_cnt_reg <= '0;
            end else begin
              slot_a_reg <= bus.in_data;
              state_reg  <= HOLD1;
            end
          end
        end
        HOLD1: begin
          if (accept) begin
            if (bus.in_last) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              drain_cnt_reg <= '0;
            end else begin
              slot_b_reg <= bus.in_data;
              state_reg  <= HOLD2;
            end
          end
        end
        HOLD2: begin
          if (accept) begin
            if (bus.in_last) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              drain_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE0;
            end
          end
        end
        DRAIN: begin
          // Hold off the next frame until the last group has left the adder.
          if (drain_cnt_reg == 3'(CSA_LAT - 1)) begin
            state_reg <= IDLE0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 3'd1;
            in_ready_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE0;
      endcase
    end
  end

  csa_tag_t tag_in;
  csa_tag_t tag_out;

  assign tag_in.valid = op_valid_reg;
  assign tag_in.last  = op_last_reg;

  csa_tag_delay #(
    .LAT(CSA_LAT)
  ) u_tag_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign bus.in_ready  = in_ready_reg;
  assign bus.op_a      = op_a_reg;
  assign bus.op_b      = op_b_reg;
  assign bus.op_c      = op_c_reg;
  assign bus.op_valid  = op_valid_reg;
  assign bus.op_last   = op_last_reg;
  assign bus.res_valid = tag_out.valid;
  assign bus.res_last  = tag_out.last;
  assign bus.grp_cnt   = grp_cnt_reg;

endmodule

// File: tb/tb_csa_operand_packer.sv
// Directed and random stimulus for the operand packer, checked cycle by cycle
// against a queue-based frame model and a behavioural 3-input adder.
module tb_csa_operand_packer;
  import csa_pkg::*;

  localparam int W   = CSA_W;
  localparam int LAT = CSA_LATENCY;

  typedef struct {
    logic         v;
    logic         l;
    logic [W+1:0] sum;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csa_operand_packer_if #(.W(W)) bus ();

  csa_operand_packer #(
    .W      (W),
    .CSA_LAT(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Stand-in for the downstream adder: fixed LAT-cycle sum of the operands.
  logic [W+1:0] s_pipe [LAT];
  always @(posedge clk) begin
    s_pipe[0] <= {2'b00, bus.op_a} + bus.op_b + bus.op_c;
    for (int i = 1; i < LAT; i++) s_pipe[i] <= s_pipe[i-1];
  end

  int           n_eval = 0;
  int           n_fail = 0;
  logic [W-1:0] words[$];
  res_t         hist[$];
  logic [W-1:0] ea, eb, ec;
  logic         ev, el, exp_ready;
  int           egrp, gap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_eval++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    words.delete();
    hist.delete();
    ea = '0; eb = '0; ec = '0;
    ev = 1'b0; el = 1'b0;
    egrp = 0; gap = 0;
    exp_ready = 1'b0;
  endtask

  task automatic check_all(input string tag);
    res_t r;
    r = '{v: 1'b0, l: 1'b0, sum: '0};
    if (hist.size() == LAT + 1) r = hist[0];
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'(exp_ready));
    check({tag, ".op_a"},      64'(bus.op_a),      64'(ea));
    check({tag, ".op_b"},      64'(bus.op_b),      64'(eb));
    check({tag, ".op_c"},      64'(bus.op_c),      64'(ec));
    check({tag, ".op_valid"},  64'(bus.op_valid),  64'(ev));
    check({tag, ".op_last"},   64'(bus.op_last),   64'(el));
    check({tag, ".grp_cnt"},   64'(bus.grp_cnt),   64'(egrp));
    check({tag, ".res_valid"}, 64'(bus.res_valid), 64'(r.v));
    check({tag, ".res_last"},  64'(bus.res_last),  64'(r.l));
    if (r.v) check({tag, ".adder_s"}, 64'(s_pipe[LAT-1]), 64'(r.sum));
  endtask

  // One clock: drive, update the frame model at the edge, compare at negedge.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic l, output logic acc);
    logic         issue;
    logic [W-1:0] g [3];
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk);
    acc   = v && exp_ready;
    issue = 1'b0;
    g[0] = '0; g[1] = '0; g[2] = '0;
    if (acc) begin
      words.push_back(d);
      if (words.size() == 3 || l) begin
        for (int i = 0; i < words.size(); i++) g[i] = words[i];
        issue = 1'b1;
        words.delete();
      end
    end
    if (ev && el) egrp = 0;
    else if (issue && egrp < 255) egrp++;
    ea = g[0]; eb = g[1]; ec = g[2];
    ev = issue;
    el = issue && l;
    if (acc && l) gap = LAT;
    else if (gap > 0) gap--;
    exp_ready = (gap == 0);
    hist.push_back('{v: ev, l: el, sum: {2'b00, ea} + eb + ec});
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    @(negedge clk);
    check_all(tag);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle("idle", 1'b0, W'($urandom), 1'b0, acc);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    logic got;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle(1);

    cycle("f123", 1'b1, 32'd1, 1'b0, acc);
    cycle("f123", 1'b1, 32'd2, 1'b0, acc);
    cycle("f123", 1'b1, 32'd3, 1'b1, acc);
    idle(5);
    $display("frame {1,2,3} done at %0t", $time);

    cycle("single", 1'b1, 32'hFFFF_FFFF, 1'b1, acc);
    idle(5);
    $display("single-word frame done at %0t", $time);

    cycle("pair", 1'b1, 32'hFFFF_FFFF, 1'b0, acc);
    cycle("pair", 1'b1, 32'h0000_0001, 1'b1, acc);
    idle(5);
    $display("two-word frame done at %0t", $time);

    for (int i = 1; i <= 9; i++) cycle("nine", 1'b1, W'(i), i == 9, acc);
    idle(5);
    $display("nine-word frame done at %0t", $time);

    cycle("drain", 1'b1, 32'd50, 1'b1, acc);
    for (int k = 0; k < 3; k++) cycle("drain_tog", k[0], W'(60 + k), k[0], acc);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) cycle("drain_wait", 1'b1, W'(100 + k), 1'b0, got);
    check("drain_accept_bound", 64'(got), 64'd1);
    cycle("drain_post", 1'b1, 32'd201, 1'b1, acc);
    idle(5);
    $display("drain gap frame done at %0t", $time);

    for (int i = 1; i <= 5; i++) cycle("pre_rst", 1'b1, W'(10 + i), 1'b0, acc);
    apply_reset();
    idle(LAT + 2);
    cycle("post_rst", 1'b1, 32'd7, 1'b1, acc);
    idle(5);
    $display("mid-frame reset done at %0t", $time);

    for (int i = 0; i < 768; i++) cycle("sat", 1'b1, W'(i), 1'b0, acc);
    cycle("sat_last", 1'b1, 32'h1234_5678, 1'b1, acc);
    idle(5);
    $display("saturation frame done at %0t", $time);

    for (int i = 0; i < 400; i++)
      cycle("rand", $urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 4) == 0, acc);
    idle(LAT + 2);
    $display("random phase done at %0t", $time);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
